imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the maximum idle cycles allowed between accepted bytes inside a session.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a load session.
REQ-006 SHALL have port rx_data, input, 8 bits: the incoming program byte.
REQ-007 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-008 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte; a byte transfers when rx_valid and rx_ready are both high.
REQ-009 SHALL have port mem_addr, output, 32 bits: the byte address for the instruction memory write port, always word-aligned.
REQ-010 SHALL have port mem_wdata, output, 32 bits: the assembled instruction word.
REQ-011 SHALL have port mem_we, output, 1 bit: a one-cycle write strobe.
REQ-012 SHALL have port cpu_hold, output, 1 bit: holds the processor in reset while high.
REQ-013 SHALL have port busy, output, 1 bit: a session is in progress.
REQ-014 SHALL have port done, output, 1 bit: sticky flag for a successful load.
REQ-015 SHALL have port error, output, 1 bit: sticky flag for a failed load.

Function
REQ-016 SHALL implement the states IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-017 In IDLE, start SHALL move to LEN, clear done, clear error, zero the byte counter and zero the word index; start SHALL be ignored in every other state.
REQ-018 In LEN, the loader SHALL accept 4 bytes, little-endian, into a 32-bit word count N.
REQ-019 After the 4th LEN byte, N=0 SHALL go to DONE, N>MEM_WORDS SHALL go to ERR, and any other N SHALL go to DATA.
REQ-020 In DATA, the loader SHALL accept bytes little-endian into the word: byte k of the word goes to bits [8k+7:8k].
REQ-021 On the 4th byte of a word, DATA SHALL go to WRITE.
REQ-022 In WRITE (exactly one cycle), mem_we=1, mem_addr=word_index*4 and mem_wdata=the assembled word.
REQ-023 WRITE SHALL then increment word_index and go to DONE if word_index+1==N, else back to DATA.
REQ-024 rx_ready SHALL be 1 only in LEN and DATA; bytes are never accepted in WRITE, IDLE, DONE or ERR.
REQ-025 mem_we SHALL be 0 in every state except WRITE; exactly N write strobes SHALL occur per successful session, at strictly increasing addresses 0, 4, …, 4(N-1).
REQ-026 The timeout counter SHALL reset on every accepted byte and on entry to LEN, and count cycles in LEN/DATA otherwise.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES, the loader SHALL go to ERR; a partially assembled word SHALL be discarded and not written.
REQ-028 busy SHALL be 1 in LEN, DATA and WRITE.
REQ-029 cpu_hold SHALL be 1 in LEN, DATA, WRITE and ERR, and 0 in IDLE and DONE.
REQ-030 DONE SHALL assert done=1 and return to IDLE on the next cycle; done stays 1 until the next start or reset.
REQ-031 ERR SHALL assert error=1 and remain in ERR, with cpu_hold=1, until reset or start.
REQ-032 start while in ERR SHALL behave as in IDLE (restart the session).
REQ-033 mem_addr and mem_wdata SHALL be registered; their value outside WRITE is don't-care but stable.

Reset
REQ-034 On reset, the state SHALL be IDLE, with rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0 and error=0, and all counters at zero.
REQ-035 Reset SHALL take priority over start and over any in-flight byte.
REQ-036 Reset mid-session SHALL abort with no further mem_we.

Verification
REQ-037 start; bytes 02 00 00 00, 13 00 00 00, 6F 00 00 00 -> mem_we at addr 0 data 0x00000013, then addr 4 data 0x0000006F; done=1; cpu_hold falls.
REQ-038 start; bytes 00 00 00 00 -> no mem_we; done=1 within 2 cycles of the 4th byte; error=0.
REQ-039 start; count 0x00001001 (4097) -> ERR: error=1, cpu_hold=1, no mem_we, rx_ready=0.
REQ-040 start; count 1; 2 data bytes then idle for TIMEOUT_CYCLES -> error=1, no mem_we; then start and a good stream -> error=0 and the load succeeds.
REQ-041 rx_valid held high continuously with rx_ready=0 in WRITE -> no byte is lost or duplicated; the words assembled match the stream.
REQ-042 reset asserted 1 cycle after the 2nd data word's 3rd byte -> all outputs at their reset values next cycle; no further mem_we; start in the same cycle as reset is ignored.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: receives a length-prefixed little-endian byte stream and writes it
// word by word into the instruction memory while holding the CPU in reset.
// Stream format: 4-byte word count N, then N words of 4 bytes each.
module imem_loader #(
  parameter int MEM_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   MAX_WORDS    = 32'(MEM_WORDS);

  state_t        state;
  state_t        state_next;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_idx;
  logic [31:0]   len_word;
  logic [31:0]   word_buf;
  logic [TW-1:0] tmo_cnt;

  logic          accept;
  logic          last_byte;
  logic          timeout_hit;
  logic          session_start;
  logic [31:0]   len_next;
  logic [31:0]   word_next;

  // Bytes arrive least significant first, so shifting each new byte in at the
  // top leaves byte k in bits [8k+7:8k] once four bytes have been taken.
  assign accept        = rx_valid && rx_ready;
  assign last_byte     = accept && (byte_cnt == 2'd3);
  assign timeout_hit   = !accept && (tmo_cnt == TIMEOUT_LAST);
  assign session_start = start && ((state == IDLE) || (state == ERR));
  assign len_next      = {rx_data, len_word[31:8]};
  assign word_next     = {rx_data, word_buf[31:8]};

  // Next-state decision for the session sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = LEN;
      end
      LEN: begin
        if (last_byte) begin
          if (len_next == 32'd0)          state_next = DONE;
          else if (len_next > MAX_WORDS)  state_next = ERR;
          else                            state_next = DATA;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DATA: begin
        if (last_byte)        state_next = WRITE;
        else if (timeout_hit) state_next = ERR;
      end
      WRITE: begin
        if (word_idx + 32'd1 == len_word) state_next = DONE;
        else                              state_next = DATA;
      end
      DONE: begin
        state_next = IDLE;
      end
      ERR: begin
        if (start) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, datapath and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      byte_cnt  <= 2'd0;
      word_idx  <= 32'd0;
      len_word  <= 32'd0;
      word_buf  <= 32'd0;
      tmo_cnt   <= '0;
    end else begin
      state    <= state_next;
      rx_ready <= (state_next == LEN) || (state_next == DATA);
      busy     <= (state_next == LEN) || (state_next == DATA) || (state_next == WRITE);
      cpu_hold <= (state_next == LEN) || (state_next == DATA) ||
                  (state_next == WRITE) || (state_next == ERR);
      mem_we   <= (state_next == WRITE);

      if (session_start) begin
        done  <= 1'b0;
        error <= 1'b0;
      end else begin
        if (state_next == DONE) done  <= 1'b1;
        if (state_next == ERR)  error <= 1'b1;
      end

      if (session_start) begin
        byte_cnt <= 2'd0;
        word_idx <= 32'd0;
        len_word <= 32'd0;
        word_buf <= 32'd0;
        tmo_cnt  <= '0;
      end else if ((state == LEN) || (state == DATA)) begin
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          tmo_cnt  <= '0;
          if (state == LEN) len_word <= len_next;
          else              word_buf <= word_next;
        end else if (timeout_hit) begin
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
        if ((state == DATA) && last_byte) begin
          mem_wdata <= word_next;
          mem_addr  <= word_idx << 2;
        end
      end else if (state == WRITE) begin
        word_idx <= word_idx + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader: randomized and directed sessions for imem_loader, checked
// against a stream-level model (expected write list plus session outcome).
module tb_imem_loader;

  localparam int MEM_WORDS = 16;
  localparam int TIMEOUT   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  stream_q[$];

  imem_loader #(
    .MEM_WORDS     (MEM_WORDS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare: every write must be the next one the model expects,
  // and the status outputs must stay mutually consistent.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (mem_we) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write: got addr %h data %h, want no write",
                   mem_addr, mem_wdata);
        end else begin
          check_output("write_addr", mem_addr, exp_addr_q.pop_front());
          check_output("write_data", mem_wdata, exp_data_q.pop_front());
        end
        check_output("ready_during_write", 32'(rx_ready), 32'd0);
      end
      check_output("addr_aligned", 32'(mem_addr[1:0]), 32'd0);
      check_output("ready_without_busy", 32'(rx_ready && !busy), 32'd0);
      check_output("busy_without_hold", 32'(busy && !cpu_hold), 32'd0);
      check_output("error_status", 32'(error && (!cpu_hold || busy)), 32'd0);
      check_output("done_status", 32'(done && (cpu_hold || error)), 32'd0);
    end
  end

  // Model: length prefix followed by random words; the first push_words words
  // are expected to be written at addresses 0, 4, 8, ...
  task automatic build_stream(input logic [31:0] n, input int words, input int push_words);
    logic [31:0] w;
    stream_q.delete();
    for (int i = 0; i < 4; i++) stream_q.push_back(n[8*i +: 8]);
    for (int j = 0; j < words; j++) begin
      w = $urandom();
      for (int k = 0; k < 4; k++) stream_q.push_back(w[8*k +: 8]);
      if (j < push_words) begin
        exp_addr_q.push_back(32'(j) * 32'd4);
        exp_data_q.push_back(w);
      end
    end
  endtask

  task automatic push_expected(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  // Offers every byte of stream_q, with random idle gaps and optional stray start
  // pulses; returns right after the edge that accepted the final byte.
  task automatic apply_stimulus(input int gap_pct, input bit poke_start);
    int idx = 0;
    int budget = 0;
    bit acc;
    while (idx < stream_q.size()) begin
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom());
      end else begin
        rx_valid = 1'b1;
        rx_data  = stream_q[idx];
      end
      start = poke_start && ($urandom_range(9) == 0);
      acc   = rx_valid && rx_ready;
      tick();
      if (acc) idx++;
      budget++;
      if (budget > 2000) begin
        checks++;
        failures++;
        $display("[TB] FAIL byte_budget: got %0d of %0d bytes accepted, want all",
                 idx, stream_q.size());
        break;
      end
    end
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_session();
    start    = 1'b1;
    rx_valid = 1'b0;
    tick();
    start    = 1'b0;
    check_output("session_ready", 32'(rx_ready), 32'd1);
    check_output("session_busy", 32'(busy), 32'd1);
    check_output("session_hold", 32'(cpu_hold), 32'd1);
    check_output("session_done_clear", 32'(done), 32'd0);
    check_output("session_error_clear", 32'(error), 32'd0);
  endtask

  task automatic wait_outcome(input bit exp_done, input bit exp_err, output int waited);
    waited = 0;
    while (!(done || error) && waited < 50) begin
      tick();
      waited++;
    end
    check_output("outcome_done", 32'(done), 32'(exp_done));
    check_output("outcome_error", 32'(error), 32'(exp_err));
    check_output("outcome_hold", 32'(cpu_hold), 32'(exp_err));
    check_output("outcome_busy", 32'(busy), 32'd0);
    check_output("outcome_ready", 32'(rx_ready), 32'd0);
    check_output("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) tick();
    check_output("sticky_done", 32'(done), 32'(exp_done));
    check_output("sticky_error", 32'(error), 32'(exp_err));
    check_output("sticky_hold", 32'(cpu_hold), 32'(exp_err));
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_output({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog: still running at %0t, want finished", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized sessions.
  initial begin
    int waited;
    logic [31:0] n;
    bit good;

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check_reset_values("idle");
    mon_en = 1'b1;

    // Two-word program with literal expectations.
    $display("[TB] two-word program");
    start_session();
    stream_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00};
    push_expected(32'h0, 32'h0000_0013);
    push_expected(32'h4, 32'h0000_006F);
    apply_stimulus(0, 1'b0);
    wait_outcome(1'b1, 1'b0, waited);
    check_output("two_word_latency_ok", 32'(waited <= 2), 32'd1);
    check_output("held_addr", mem_addr, 32'h4);
    check_output("held_wdata", mem_wdata, 32'h0000_006F);

    // Empty program.
    $display("[TB] empty program");
    start_session();
    build_stream(32'd0, 0, 0);
    apply_stimulus(0, 1'b0);
    wait_outcome(1'b1, 1'b0, waited);
    check_output("empty_latency_ok", 32'(waited <= 2), 32'd1);

    // Oversized counts, then bytes offered while stuck in the error state.
    $display("[TB] oversized counts");
    start_session();
    build_stream(32'h0000_1001, 0, 0);
    apply_stimulus(0, 1'b0);
    wait_outcome(1'b0, 1'b1, waited);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (4) begin
      tick();
      check_output("err_ready", 32'(rx_ready), 32'd0);
      check_output("err_sticky", 32'(error), 32'd1);
    end
    rx_valid = 1'b0;
    start_session();
    build_stream(32'(MEM_WORDS + 1), 0, 0);
    apply_stimulus(0, 1'b0);
    wait_outcome(1'b0, 1'b1, waited);

    // Largest legal program.
    $display("[TB] full memory");
    start_session();
    build_stream(32'(MEM_WORDS), MEM_WORDS, MEM_WORDS);
    apply_stimulus(20, 1'b1);
    wait_outcome(1'b1, 1'b0, waited);

    // Timeout while waiting for the length.
    $display("[TB] length timeout");
    start_session();
    repeat (TIMEOUT - 1) tick();
    check_output("len_tmo_early", 32'(error), 32'd0);
    tick();
    check_output("len_tmo_error", 32'(error), 32'd1);
    check_output("len_tmo_hold", 32'(cpu_hold), 32'd1);

    // Timeout mid-word: partial word discarded, then a clean restart.
    $display("[TB] data timeout");
    start_session();
    build_stream(32'd1, 1, 0);
    while (stream_q.size() > 6) void'(stream_q.pop_back());
    apply_stimulus(0, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check_output("data_tmo_early", 32'(error), 32'd0);
    check_output("data_tmo_busy", 32'(busy), 32'd1);
    tick();
    wait_outcome(1'b0, 1'b1, waited);
    check_output("data_tmo_latency", 32'(waited), 32'd0);
    start_session();
    build_stream(32'd3, 3, 3);
    apply_stimulus(25, 1'b0);
    wait_outcome(1'b1, 1'b0, waited);

    // Continuous valid, including across the write cycles.
    $display("[TB] back-to-back bytes");
    start_session();
    build_stream(32'd5, 5, 5);
    apply_stimulus(0, 1'b0);
    wait_outcome(1'b1, 1'b0, waited);

    // Reset mid-session with a simultaneous start.
    $display("[TB] reset abort");
    start_session();
    build_stream(32'd3, 3, 1);
    while (stream_q.size() > 11) void'(stream_q.pop_back());
    apply_stimulus(0, 1'b0);
    tick();
    reset    = 1'b1;
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hC3;
    tick();
    check_reset_values("abort");
    reset = 1'b0;
    start = 1'b0;
    repeat (4) begin
      tick();
      check_output("abort_ready", 32'(rx_ready), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_hold", 32'(cpu_hold), 32'd0);
    end
    rx_valid = 1'b0;
    check_output("abort_writes_left", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();

    // Randomized sessions.
    $display("[TB] random sessions");
    for (int s = 0; s < 12; s++) begin
      case ($urandom_range(9))
        0: begin
          n = $urandom();
          if (n <= 32'(MEM_WORDS)) n = n + 32'(MEM_WORDS + 1);
        end
        1:       n = 32'd0;
        default: n = 32'($urandom_range(MEM_WORDS, 1));
      endcase
      good = (n <= 32'(MEM_WORDS));
      start_session();
      build_stream(n, good ? int'(n) : 0, good ? int'(n) : 0);
      apply_stimulus(30, 1'b1);
      wait_outcome(good, !good, waited);
      check_output("random_latency_ok", 32'(waited <= 2), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
